dma_arbiter: RTL

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter_if.sv | 26 ++
 rtl/dma_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dma_arbiter_if.sv
// Bus bundle between the DMA arbiter, its four devices and the processor board.
// The arbiter takes the master modport; the environment side takes slave.
interface dma_arbiter_if;
    logic [3:0]  dev_req;
    logic [3:0]  dev_stb;
    logic [71:0] dev_adr18;
    logic [3:0]  dev_gnt;
    logic [3:0]  dev_ack;
    logic        dma_req;
    logic        dma_ack;
    logic [17:0] dma_adr18;
    logic        dma_stb;
    logic        global_ack;
    logic        busy;
    logic [1:0]  owner;

    modport master (
        input  dev_req, dev_stb, dev_adr18, dma_ack, global_ack,
        output dev_gnt, dev_ack, dma_req, dma_adr18, dma_stb, busy, owner
    );

    modport slave (
        output dev_req, dev_stb, dev_adr18, dma_ack, global_ack,
        input  dev_gnt, dev_ack, dma_req, dma_adr18, dma_stb, busy, owner
    );
endinterface

// File: rtl/dma_arbiter.sv
// Four-device DMA arbiter for the UNIBUS board path with burst-limited tenure.
// Define DMA_ARB_RR_EN for round-robin selection; fixed lowest-index priority otherwise.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no tenure; picks a winner when a device requests and dma_ack=0
// WAITACK  | dma_req raised for the latched owner, waiting for dma_ack
// OWN      | owner granted; address/strobe muxed to the board
// DRAIN    | request and grant dropped, waiting for dma_ack to fall
module dma_arbiter #(
    parameter int BURST = 16
) (
    input  logic          clk_p,
    input  logic          rst_n,
    dma_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAITACK = 2'd1;
    localparam logic [1:0] ST_OWN     = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam logic [7:0] BURST_C = 8'(BURST);

    logic [1:0]  state;
    logic [1:0]  owner_q;
    logic [3:0]  gnt_q;
    logic        dma_req_q;
    logic [7:0]  burst_cnt;

    logic [1:0]  winner;
    logic [3:0]  owner_oh;
    logic        own_req;
    logic        own_stb;
    logic [17:0] own_adr;
    logic        in_own;
    logic        xfer;
    logic        others_pending;
    logic        yield_now;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd3;
        casez (v)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

`ifdef DMA_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [7:0] req_dbl;

    // Rotate the request vector so the search starts at rr_ptr, then undo the rotation.
    always_comb begin
        req_dbl = {bus.dev_req, bus.dev_req} >> rr_ptr;
        winner  = rr_ptr + lowest_set(req_dbl[3:0]);
    end
`else
    always_comb begin
        winner = lowest_set(bus.dev_req);
    end
`endif

    always_comb begin
        own_adr = '0;
        case (owner_q)
            2'd0:    own_adr = bus.dev_adr18[17:0];
            2'd1:    own_adr = bus.dev_adr18[35:18];
            2'd2:    own_adr = bus.dev_adr18[53:36];
            default: own_adr = bus.dev_adr18[71:54];
        endcase
    end

    assign owner_oh       = 4'b0001 << owner_q;
    assign own_req        = bus.dev_req[owner_q];
    assign own_stb        = bus.dev_stb[owner_q];
    assign in_own         = (state == ST_OWN);
    assign others_pending = |(bus.dev_req & ~owner_oh);

    assign bus.dma_stb   = in_own & own_stb & gnt_q[owner_q];
    assign bus.dma_adr18 = in_own ? own_adr : 18'd0;
    assign xfer          = bus.global_ack & bus.dma_stb;
    assign bus.dev_ack   = xfer ? owner_oh : 4'b0000;

    assign bus.dev_gnt = gnt_q;
    assign bus.dma_req = dma_req_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.owner   = owner_q;

    // Yield only between transfers: the owner's strobe must be low.
    assign yield_now = (burst_cnt == BURST_C) && others_pending && !own_stb;

    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner_q   <= 2'd0;
            gnt_q     <= 4'b0000;
            dma_req_q <= 1'b0;
            burst_cnt <= 8'd0;
`ifdef DMA_ARB_RR_EN
            rr_ptr    <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.dev_req && !bus.dma_ack) begin
                        owner_q   <= winner;
                        dma_req_q <= 1'b1;
                        state     <= ST_WAITACK;
                    end
                end
                ST_WAITACK: begin
                    if (!own_req) begin
                        dma_req_q <= 1'b0;
                        state     <= ST_DRAIN;
                    end else if (bus.dma_ack) begin
                        gnt_q     <= owner_oh;
                        burst_cnt <= 8'd0;
                        state     <= ST_OWN;
`ifdef DMA_ARB_RR_EN
                        rr_ptr    <= owner_q + 2'd1;
`endif
                    end
                end
                ST_OWN: begin
                    if (xfer && (burst_cnt != BURST_C)) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    if (!own_req || yield_now) begin
                        dma_req_q <= 1'b0;
                        gnt_q     <= 4'b0000;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.dma_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
